// File: rtl/gyro_loop_seq.sv
// Start-up and lock sequencer for the gyro closed-loop integrator: clears the
// integrator, ramps the gain index to target, then tracks lock on the error window.
module gyro_loop_seq #(
  parameter int ZERO_CYC = 4,
  parameter int HOLD_CYC = 3
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic        i_abort,
  input  logic        i_err_valid,
  input  logic [31:0] i_err,
  input  logic [5:0]  i_gain_start,
  input  logic [5:0]  i_gain_target,
  input  logic [15:0] i_dwell,
  input  logic [31:0] i_lock_th,
  input  logic [7:0]  i_lock_cnt,
  input  logic [15:0] i_timeout,
  output logic [5:0]  o_gain_sel,
  output logic        o_en,
  output logic [31:0] o_err,
  output logic        o_zero,
  output logic        o_gain_mode,
  output logic [2:0]  o_state,
  output logic        o_busy,
  output logic        o_locked,
  output logic        o_done,
  output logic        o_fault
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ZERO  = 3'd1;
  localparam logic [2:0] S_RAMP  = 3'd2;
  localparam logic [2:0] S_LOCK  = 3'd3;
  localparam logic [2:0] S_RUN   = 3'd4;
  localparam logic [2:0] S_FAULT = 3'd5;

  localparam logic [15:0] ZCYC = 16'(ZERO_CYC);
  localparam logic [15:0] HCYC = 16'(HOLD_CYC);

  // -2^31 has no positive twin in 32 bits, so it saturates to 2^31-1.
  function automatic logic [31:0] abs32(input logic [31:0] v);
    if (v == 32'h8000_0000) begin
      abs32 = 32'h7FFF_FFFF;
    end else if (v[31]) begin
      abs32 = ~v + 32'd1;
    end else begin
      abs32 = v;
    end
  endfunction

  function automatic logic [5:0] clamp15(input logic [5:0] v);
    clamp15 = (v > 6'd15) ? 6'd15 : v;
  endfunction

  function automatic logic [15:0] inc16(input logic [15:0] v);
    inc16 = (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [7:0] inc8(input logic [7:0] v);
    inc8 = (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [2:0]  state_q, state_d;
  logic [5:0]  gain_q, gain_d;
  logic [5:0]  tgt_q, tgt_d;
  logic [15:0] zcnt_q, zcnt_d;
  logic [15:0] hold_q, hold_d;
  logic [15:0] dwell_q, dwell_d;
  logic [7:0]  lk_q, lk_d;
  logic [15:0] to_q, to_d;
  logic [31:0] err_q, err_d;
  logic        en_q, en_d;
  logic        zero_q, zero_d;
  logic        gm_q, gm_d;
  logic        done_q, done_d;
  logic        busy_q, busy_d;
  logic        locked_q, locked_d;
  logic        fault_q, fault_d;

  logic        in_win;
  logic [15:0] dwell_eff;
  logic [7:0]  lcnt_eff;
  logic [15:0] dwell_nx;
  logic [7:0]  lk_nx;
  logic [15:0] to_nx;

  // Next-state, counter and output computation.
  always_comb begin
    state_d   = state_q;
    gain_d    = gain_q;
    tgt_d     = tgt_q;
    zcnt_d    = zcnt_q;
    hold_d    = hold_q;
    dwell_d   = dwell_q;
    lk_d      = lk_q;
    to_d      = to_q;
    en_d      = 1'b0;
    done_d    = 1'b0;
    dwell_nx  = inc16(dwell_q);
    lk_nx     = lk_q;
    to_nx     = inc16(to_q);
    in_win    = (abs32(i_err) <= i_lock_th);
    dwell_eff = (i_dwell == 16'd0) ? 16'd1 : i_dwell;
    lcnt_eff  = (i_lock_cnt == 8'd0) ? 8'd1 : i_lock_cnt;
    if (i_err_valid) begin
      err_d = i_err;
    end else begin
      err_d = err_q;
    end

    if (i_abort) begin
      state_d = S_IDLE;
      zcnt_d  = 16'd0;
      hold_d  = 16'd0;
      dwell_d = 16'd0;
      lk_d    = 8'd0;
      to_d    = 16'd0;
    end else begin
      case (state_q)
        S_IDLE, S_FAULT: begin
          if (i_start) begin
            state_d = S_ZERO;
            gain_d  = clamp15(i_gain_start);
            tgt_d   = clamp15(i_gain_target);
            zcnt_d  = ZCYC;
            hold_d  = 16'd0;
            dwell_d = 16'd0;
            lk_d    = 8'd0;
            to_d    = 16'd0;
          end else begin
            state_d = state_q;
          end
        end
        S_ZERO: begin
          if (zcnt_q <= 16'd1) begin
            zcnt_d  = 16'd0;
            state_d = (gain_q != tgt_q) ? S_RAMP : S_LOCK;
          end else begin
            zcnt_d = zcnt_q - 16'd1;
          end
        end
        S_RAMP: begin
          // Leave for LOCK exactly as the hold window after the last step closes.
          if (hold_q != 16'd0) begin
            hold_d = hold_q - 16'd1;
            if ((hold_q == 16'd1) && (gain_q == tgt_q)) begin
              state_d = S_LOCK;
            end else begin
              state_d = S_RAMP;
            end
          end else if (gain_q == tgt_q) begin
            state_d = S_LOCK;
          end else if (i_err_valid) begin
            if (dwell_nx >= dwell_eff) begin
              gain_d  = (gain_q < tgt_q) ? gain_q + 6'd1 : gain_q - 6'd1;
              dwell_d = 16'd0;
              hold_d  = HCYC;
            end else begin
              dwell_d = dwell_nx;
              en_d    = 1'b1;
            end
          end else begin
            dwell_d = dwell_q;
          end
        end
        S_LOCK: begin
          if (i_err_valid) begin
            en_d  = 1'b1;
            lk_nx = in_win ? inc8(lk_q) : 8'd0;
            if (lk_nx >= lcnt_eff) begin
              state_d = S_RUN;
              done_d  = 1'b1;
              lk_d    = 8'd0;
              to_d    = 16'd0;
            end else if ((i_timeout != 16'd0) && (to_nx >= i_timeout)) begin
              state_d = S_FAULT;
              en_d    = 1'b0;
              lk_d    = 8'd0;
              to_d    = 16'd0;
            end else begin
              lk_d = lk_nx;
              to_d = to_nx;
            end
          end else begin
            lk_d = lk_q;
          end
        end
        S_RUN: begin
          if (i_err_valid) begin
            en_d  = 1'b1;
            lk_nx = in_win ? 8'd0 : inc8(lk_q);
            if (lk_nx >= lcnt_eff) begin
              state_d = S_LOCK;
              lk_d    = 8'd0;
              to_d    = 16'd0;
            end else begin
              lk_d = lk_nx;
            end
          end else begin
            lk_d = lk_q;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    zero_d   = (state_d == S_ZERO);
    gm_d     = (state_d == S_RAMP);
    busy_d   = (state_d == S_ZERO) || (state_d == S_RAMP) || (state_d == S_LOCK);
    locked_d = (state_d == S_RUN);
    fault_d  = (state_d == S_FAULT);
  end

  // State and output registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= S_IDLE;
      gain_q   <= 6'd5;
      tgt_q    <= 6'd5;
      zcnt_q   <= 16'd0;
      hold_q   <= 16'd0;
      dwell_q  <= 16'd0;
      lk_q     <= 8'd0;
      to_q     <= 16'd0;
      err_q    <= 32'd0;
      en_q     <= 1'b0;
      zero_q   <= 1'b0;
      gm_q     <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      locked_q <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      gain_q   <= gain_d;
      tgt_q    <= tgt_d;
      zcnt_q   <= zcnt_d;
      hold_q   <= hold_d;
      dwell_q  <= dwell_d;
      lk_q     <= lk_d;
      to_q     <= to_d;
      err_q    <= err_d;
      en_q     <= en_d;
      zero_q   <= zero_d;
      gm_q     <= gm_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      locked_q <= locked_d;
      fault_q  <= fault_d;
    end
  end

  assign o_gain_sel  = gain_q;
  assign o_en        = en_q;
  assign o_err       = err_q;
  assign o_zero      = zero_q;
  assign o_gain_mode = gm_q;
  assign o_state     = state_q;
  assign o_busy      = busy_q;
  assign o_locked    = locked_q;
  assign o_done      = done_q;
  assign o_fault     = fault_q;

endmodule

// File: tb/tb_gyro_loop_seq.sv
// Directed bench for gyro_loop_seq: ramp, lock entry/loss, timeout, clamping,
// abort and asynchronous reset, with hand-computed expectations.
module tb_gyro_loop_seq;

  logic        clk = 1'b0;
  logic        i_rst, i_start, i_abort, i_err_valid;
  logic [31:0] i_err, i_lock_th;
  logic [5:0]  i_gain_start, i_gain_target;
  logic [15:0] i_dwell, i_timeout;
  logic [7:0]  i_lock_cnt;
  logic [5:0]  o_gain_sel;
  logic        o_en, o_zero, o_gain_mode, o_busy, o_locked, o_done, o_fault;
  logic [31:0] o_err;
  logic [2:0]  o_state;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  gyro_loop_seq #(.ZERO_CYC(4), .HOLD_CYC(3)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .i_abort(i_abort),
    .i_err_valid(i_err_valid), .i_err(i_err), .i_gain_start(i_gain_start),
    .i_gain_target(i_gain_target), .i_dwell(i_dwell), .i_lock_th(i_lock_th),
    .i_lock_cnt(i_lock_cnt), .i_timeout(i_timeout), .o_gain_sel(o_gain_sel),
    .o_en(o_en), .o_err(o_err), .o_zero(o_zero), .o_gain_mode(o_gain_mode),
    .o_state(o_state), .o_busy(o_busy), .o_locked(o_locked), .o_done(o_done),
    .o_fault(o_fault)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic samp(input logic [31:0] e);
    i_err_valid = 1'b1;
    i_err       = e;
    tick();
    i_err_valid = 1'b0;
  endtask

  task automatic pulse_start();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  initial begin
    i_rst = 1'b1; i_start = 1'b0; i_abort = 1'b0; i_err_valid = 1'b0;
    i_err = 32'd0; i_lock_th = 32'd100; i_gain_start = 6'd2; i_gain_target = 6'd5;
    i_dwell = 16'd4; i_timeout = 16'd0; i_lock_cnt = 8'd3;
    idle(2);
    chk("rst_gain", 32'(o_gain_sel), 32'd5);
    chk("rst_state", 32'(o_state), 32'd0);
    chk("rst_err", o_err, 32'd0);
    chk("rst_en", 32'(o_en), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    i_rst = 1'b0;
    idle(1);

    // Up-ramp 2 -> 5, dwell 4
    pulse_start();
    chk("up_zero", 32'(o_zero), 32'd1);
    chk("up_state_zero", 32'(o_state), 32'd1);
    chk("up_gain0", 32'(o_gain_sel), 32'd2);
    chk("up_busy", 32'(o_busy), 32'd1);
    idle(3);
    chk("up_zero_last", 32'(o_zero), 32'd1);
    idle(1);
    chk("up_ramp", 32'(o_state), 32'd2);
    chk("up_zero_off", 32'(o_zero), 32'd0);
    chk("up_gm", 32'(o_gain_mode), 32'd1);
    samp(32'd11);
    chk("up_en", 32'(o_en), 32'd1);
    chk("up_err", o_err, 32'd11);
    samp(32'd22); samp(32'd33); samp(32'd44);
    chk("up_step3", 32'(o_gain_sel), 32'd3);
    chk("up_step_en", 32'(o_en), 32'd0);
    idle(2);
    samp(32'd55);
    chk("hold_last_en", 32'(o_en), 32'd0);
    samp(32'd66);
    chk("hold_over_en", 32'(o_en), 32'd1);
    chk("hold_over_err", o_err, 32'd66);
    samp(32'd1); samp(32'd2); samp(32'd3);
    chk("up_step4", 32'(o_gain_sel), 32'd4);
    idle(4);
    for (int i = 0; i < 4; i++) samp(32'd0);
    chk("up_step5", 32'(o_gain_sel), 32'd5);
    chk("up_still_ramp", 32'(o_state), 32'd2);
    idle(2);
    chk("up_hold_ramp", 32'(o_state), 32'd2);
    idle(1);
    chk("up_lock", 32'(o_state), 32'd3);
    chk("up_gm_off", 32'(o_gain_mode), 32'd0);

    // Lock entry, th=100 cnt=3
    samp(32'd50); samp(32'hFFFF_FF9C); samp(32'd200); samp(32'd10); samp(32'hFFFF_FFFB);
    chk("le_state", 32'(o_state), 32'd3);
    chk("le_err", o_err, 32'hFFFF_FFFB);
    samp(32'd99);
    chk("le_run", 32'(o_state), 32'd4);
    chk("le_done", 32'(o_done), 32'd1);
    chk("le_locked", 32'(o_locked), 32'd1);
    idle(1);
    chk("le_done_pulse", 32'(o_done), 32'd0);
    chk("le_locked_hold", 32'(o_locked), 32'd1);

    // Lock loss, cnt=2
    i_lock_cnt = 8'd2;
    samp(32'd150); samp(32'd20); samp(32'hFFFF_FED4);
    chk("ll_still_run", 32'(o_state), 32'd4);
    samp(32'd101);
    chk("ll_lock", 32'(o_state), 32'd3);
    chk("ll_locked_off", 32'(o_locked), 32'd0);

    // Timeout of 10 samples
    i_timeout = 16'd10;
    for (int i = 0; i < 9; i++) samp(32'd1000);
    chk("to_9", 32'(o_state), 32'd3);
    samp(32'd1000);
    chk("to_fault_state", 32'(o_state), 32'd5);
    chk("to_fault", 32'(o_fault), 32'd1);
    chk("to_en", 32'(o_en), 32'd0);
    chk("to_gain", 32'(o_gain_sel), 32'd5);

    // Restart from FAULT: down-ramp, clamped start, dwell 0
    i_timeout = 16'd0; i_gain_start = 6'd40; i_gain_target = 6'd13; i_dwell = 16'd0;
    pulse_start();
    chk("dn_zero", 32'(o_zero), 32'd1);
    chk("dn_fault_off", 32'(o_fault), 32'd0);
    chk("dn_clamp", 32'(o_gain_sel), 32'd15);
    idle(4);
    chk("dn_ramp", 32'(o_state), 32'd2);
    samp(32'd1);
    chk("dn_14", 32'(o_gain_sel), 32'd14);
    idle(4);
    samp(32'd2);
    chk("dn_13", 32'(o_gain_sel), 32'd13);
    idle(3);
    chk("dn_lock", 32'(o_state), 32'd3);
    i_abort = 1'b1; tick(); i_abort = 1'b0;
    chk("ab_lock_idle", 32'(o_state), 32'd0);

    // start == target skips RAMP
    i_gain_start = 6'd7; i_gain_target = 6'd7;
    pulse_start();
    chk("eq_gain", 32'(o_gain_sel), 32'd7);
    for (int i = 0; i < 4; i++) begin
      chk("eq_gm", 32'(o_gain_mode), 32'd0);
      tick();
    end
    chk("eq_gm_end", 32'(o_gain_mode), 32'd0);
    chk("eq_lock", 32'(o_state), 32'd3);

    // Most-negative error is in-window for th=0x7FFFFFFF
    i_lock_th = 32'h7FFF_FFFF; i_lock_cnt = 8'd1;
    samp(32'h8000_0000);
    chk("min_run", 32'(o_state), 32'd4);
    chk("min_done", 32'(o_done), 32'd1);
    chk("min_err", o_err, 32'h8000_0000);

    // Abort + start during a RAMP hold window
    i_abort = 1'b1; tick(); i_abort = 1'b0;
    i_gain_start = 6'd3; i_gain_target = 6'd6; i_dwell = 16'd1;
    pulse_start();
    idle(4);
    samp(32'd5);
    chk("ab_step", 32'(o_gain_sel), 32'd4);
    i_abort = 1'b1; i_start = 1'b1; i_err_valid = 1'b1;
    tick();
    i_abort = 1'b0; i_start = 1'b0; i_err_valid = 1'b0;
    chk("ab_idle", 32'(o_state), 32'd0);
    chk("ab_en", 32'(o_en), 32'd0);
    chk("ab_gain", 32'(o_gain_sel), 32'd4);
    chk("ab_zero", 32'(o_zero), 32'd0);
    chk("ab_gm", 32'(o_gain_mode), 32'd0);

    // Asynchronous reset while in RUN
    i_gain_start = 6'd9; i_gain_target = 6'd9; i_lock_th = 32'd200;
    pulse_start();
    idle(4);
    samp(32'd123);
    chk("rr_run", 32'(o_state), 32'd4);
    #2; i_rst = 1'b1; #1;
    chk("ar_gain", 32'(o_gain_sel), 32'd5);
    chk("ar_state", 32'(o_state), 32'd0);
    chk("ar_locked", 32'(o_locked), 32'd0);
    chk("ar_err", o_err, 32'd0);
    chk("ar_en", 32'(o_en), 32'd0);
    chk("ar_done", 32'(o_done), 32'd0);
    tick();
    i_rst = 1'b0;
    pulse_start();
    chk("ar_restart", 32'(o_state), 32'd1);
    chk("ar_restart_zero", 32'(o_zero), 32'd1);
    chk("ar_restart_gain", 32'(o_gain_sel), 32'd9);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
